wb_initiator: RTL and testbench

WB_INITIATOR -- requirements
Module: wb_initiator

---
 rtl/wb_initiator_pkg.sv | 12 +
 rtl/wb_timeout_cnt.sv | 24 ++
 rtl/wb_initiator.sv | 108 ++++++++++
 tb/tb_wb_initiator.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_initiator_pkg.sv
// Shared types and bus widths for the Wishbone classic initiator.
package wb_initiator_pkg;
  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;
endpackage

// File: rtl/wb_timeout_cnt.sv
// Saturating wait counter; expired marks the edge on which the count reaches limit.
module wb_timeout_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A zero limit never expires, so the bus may wait forever.
  assign expired = enable && (limit != '0) && (cnt_q == limit - 1'b1);
endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic master driven by a valid/ready command
// port, returning read data or a timeout error on a valid/ready response port.
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [WB_AW-1:0] cmd_adr,
  input  logic [WB_DW-1:0] cmd_wdata,
  input  logic [WB_SW-1:0] cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WB_DW-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [WB_AW-1:0] wbm_adr_o,
  output logic [WB_DW-1:0] wbm_dat_o,
  output logic [WB_SW-1:0] wbm_sel_o,
  input  logic             wbm_ack_i,
  input  logic [WB_DW-1:0] wbm_dat_i
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  state_e state_q, state_d;
  logic   we_q;
  logic   accept;
  logic   in_bus;
  logic   tmo;

  assign accept = cmd_valid && cmd_ready;
  assign in_bus = (state_q == ST_BUS);

  wb_timeout_cnt #(
    .CNT_W (CNT_W)
  ) u_tmo (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .clear   (accept),
    .enable  (in_bus && !wbm_ack_i),
    .limit   (LIMIT),
    .expired (tmo)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = ST_BUS;
      end
      ST_BUS: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = we_q;
        if (wbm_ack_i || tmo) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request is latched on accept; response is captured when the bus phase ends.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      we_q      <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q      <= cmd_we;
        wbm_adr_o <= cmd_adr;
        wbm_dat_o <= cmd_wdata;
        wbm_sel_o <= cmd_sel;
      end
      if (in_bus && wbm_ack_i) begin
        rsp_rdata <= we_q ? '0 : wbm_dat_i;
        rsp_err   <= 1'b0;
      end else if (in_bus && tmo) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_wb_initiator.sv
// Randomized bench for wb_initiator: two instances (TIMEOUT 4 and 3) checked
// against a per-transaction reference model.
module tb_wb_initiator;
  logic        clk;
  logic        rst_n;
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic        cmd_we    [2];
  logic [31:0] cmd_adr   [2];
  logic [31:0] cmd_wdata [2];
  logic [3:0]  cmd_sel   [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        wbm_cyc   [2];
  logic        wbm_stb   [2];
  logic        wbm_we    [2];
  logic [31:0] wbm_adr   [2];
  logic [31:0] wbm_dato  [2];
  logic [3:0]  wbm_sel   [2];
  logic        wbm_ack   [2];
  logic [31:0] wbm_dati  [2];

  int n_chk;
  int n_fail;
  int to_of [2];

  wb_initiator #(.TIMEOUT(4)) u0 (
    .wb_clk_i (clk), .wb_rst_ni (rst_n),
    .cmd_valid (cmd_valid[0]), .cmd_ready (cmd_ready[0]), .cmd_we (cmd_we[0]),
    .cmd_adr (cmd_adr[0]), .cmd_wdata (cmd_wdata[0]), .cmd_sel (cmd_sel[0]),
    .rsp_valid (rsp_valid[0]), .rsp_ready (rsp_ready[0]),
    .rsp_rdata (rsp_rdata[0]), .rsp_err (rsp_err[0]),
    .wbm_cyc_o (wbm_cyc[0]), .wbm_stb_o (wbm_stb[0]), .wbm_we_o (wbm_we[0]),
    .wbm_adr_o (wbm_adr[0]), .wbm_dat_o (wbm_dato[0]), .wbm_sel_o (wbm_sel[0]),
    .wbm_ack_i (wbm_ack[0]), .wbm_dat_i (wbm_dati[0])
  );

  wb_initiator #(.TIMEOUT(3)) u1 (
    .wb_clk_i (clk), .wb_rst_ni (rst_n),
    .cmd_valid (cmd_valid[1]), .cmd_ready (cmd_ready[1]), .cmd_we (cmd_we[1]),
    .cmd_adr (cmd_adr[1]), .cmd_wdata (cmd_wdata[1]), .cmd_sel (cmd_sel[1]),
    .rsp_valid (rsp_valid[1]), .rsp_ready (rsp_ready[1]),
    .rsp_rdata (rsp_rdata[1]), .rsp_err (rsp_err[1]),
    .wbm_cyc_o (wbm_cyc[1]), .wbm_stb_o (wbm_stb[1]), .wbm_we_o (wbm_we[1]),
    .wbm_adr_o (wbm_adr[1]), .wbm_dat_o (wbm_dato[1]), .wbm_sel_o (wbm_sel[1]),
    .wbm_ack_i (wbm_ack[1]), .wbm_dat_i (wbm_dati[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the transfer ends on the ack cycle unless the limit is reached first;
  // an ack on the limit cycle still counts as success.
  function automatic bit ack_wins(input int to, input int ack_at);
    return (ack_at != 0) && ((to == 0) || (ack_at <= to));
  endfunction

  function automatic int exp_bus_cycles(input int to, input int ack_at);
    return ack_wins(to, ack_at) ? ack_at : to;
  endfunction

  task automatic run_txn(input int u, input logic we, input logic [31:0] adr,
                         input logic [31:0] wd, input logic [3:0] sel, input int ack_at,
                         input logic [31:0] rd, input int hold, input bit keep_valid);
    int          n;
    bit          ok;
    logic [31:0] e_rd;
    chk("cmd_ready_idle", 32'(cmd_ready[u]), 32'd1);
    cmd_valid[u] = 1'b1;
    cmd_we[u]    = we;
    cmd_adr[u]   = adr;
    cmd_wdata[u] = wd;
    cmd_sel[u]   = sel;
    tick();
    cmd_valid[u] = 1'b0;
    cmd_wdata[u] = $urandom;
    cmd_adr[u]   = $urandom;
    n = 0;
    while (wbm_cyc[u] && n < 300) begin
      n++;
      chk("bus_stb", 32'(wbm_stb[u]), 32'd1);
      chk("bus_we", 32'(wbm_we[u]), 32'(we));
      chk("bus_adr", wbm_adr[u], adr);
      chk("bus_dat", wbm_dato[u], wd);
      chk("bus_sel", 32'(wbm_sel[u]), 32'(sel));
      chk("bus_cmd_ready", 32'(cmd_ready[u]), 32'd0);
      if (n == ack_at) begin
        wbm_ack[u]  = 1'b1;
        wbm_dati[u] = rd;
      end else begin
        wbm_dati[u] = $urandom;
      end
      tick();
      wbm_ack[u] = 1'b0;
    end
    chk("bus_cycles", 32'(n), 32'(exp_bus_cycles(to_of[u], ack_at)));
    ok   = ack_wins(to_of[u], ack_at);
    e_rd = (ok && !we) ? rd : 32'd0;
    chk("rsp_valid", 32'(rsp_valid[u]), 32'd1);
    chk("rsp_rdata", rsp_rdata[u], e_rd);
    chk("rsp_err", 32'(rsp_err[u]), 32'(!ok));
    chk("end_stb", 32'(wbm_stb[u]), 32'd0);
    chk("end_we", 32'(wbm_we[u]), 32'd0);
    chk("end_adr_hold", wbm_adr[u], adr);
    if (keep_valid) cmd_valid[u] = 1'b1;
    rsp_ready[u] = 1'b0;
    for (int i = 0; i < hold; i++) begin
      wbm_ack[u] = 1'($urandom);
      tick();
      chk("hold_valid", 32'(rsp_valid[u]), 32'd1);
      chk("hold_rdata", rsp_rdata[u], e_rd);
      chk("hold_err", 32'(rsp_err[u]), 32'(!ok));
      chk("hold_cmd_ready", 32'(cmd_ready[u]), 32'd0);
      chk("hold_cyc", 32'(wbm_cyc[u]), 32'd0);
    end
    wbm_ack[u]   = 1'b0;
    rsp_ready[u] = 1'b1;
    tick();
    rsp_ready[u] = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid[u]), 32'd0);
    chk("post_cmd_ready", 32'(cmd_ready[u]), 32'd1);
    chk("post_cyc", 32'(wbm_cyc[u]), 32'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    to_of[0] = 4;
    to_of[1] = 3;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      cmd_valid[u] = 1'b0; cmd_we[u] = 1'b0; cmd_adr[u] = '0; cmd_wdata[u] = '0;
      cmd_sel[u] = '0; rsp_ready[u] = 1'b0; wbm_ack[u] = 1'b0; wbm_dati[u] = '0;
    end
    repeat (3) tick();
    for (int u = 0; u < 2; u++) begin
      chk("rst_cmd_ready", 32'(cmd_ready[u]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid[u]), 32'd0);
      chk("rst_rdata", rsp_rdata[u], 32'd0);
      chk("rst_err", 32'(rsp_err[u]), 32'd0);
      chk("rst_cyc", 32'(wbm_cyc[u]), 32'd0);
      chk("rst_stb", 32'(wbm_stb[u]), 32'd0);
      chk("rst_we", 32'(wbm_we[u]), 32'd0);
      chk("rst_adr", wbm_adr[u], 32'd0);
      chk("rst_dat", wbm_dato[u], 32'd0);
      chk("rst_sel", 32'(wbm_sel[u]), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    run_txn(0, 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 2, 32'h5555_AAAA, 0, 1'b0);
    run_txn(0, 1'b0, 32'h3000_0000, 32'h0, 4'hF, 1, 32'h1234_5678, 0, 1'b0);
    run_txn(0, 1'b0, 32'h3000_0008, 32'h0, 4'h3, 0, 32'h0, 1, 1'b0);
    run_txn(0, 1'b1, 32'h3000_000C, 32'hA5A5_0F0F, 4'hC, 1, 32'h0, 5, 1'b1);
    run_txn(0, 1'b0, 32'h3000_0010, 32'h0, 4'hF, 3, 32'h0BAD_F00D, 0, 1'b0);
    run_txn(1, 1'b0, 32'h4000_0000, 32'h0, 4'hF, 3, 32'hCAFE_F00D, 0, 1'b0);
    run_txn(1, 1'b1, 32'h4000_0004, 32'h1111_2222, 4'h1, 0, 32'h0, 2, 1'b0);

    // Stray acks while idle must not produce a response.
    for (int i = 0; i < 3; i++) begin
      wbm_ack[0] = 1'b1;
      wbm_dati[0] = $urandom;
      tick();
      chk("stray_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("stray_cmd_ready", 32'(cmd_ready[0]), 32'd1);
      chk("stray_cyc", 32'(wbm_cyc[0]), 32'd0);
    end
    wbm_ack[0] = 1'b0;

    // Reset pulse in the middle of a bus phase aborts the transfer.
    cmd_valid[0] = 1'b1; cmd_we[0] = 1'b0; cmd_adr[0] = 32'h3000_0020; cmd_sel[0] = 4'hF;
    tick();
    cmd_valid[0] = 1'b0;
    tick();
    chk("mid_cyc", 32'(wbm_cyc[0]), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_cyc", 32'(wbm_cyc[0]), 32'd0);
    chk("abort_stb", 32'(wbm_stb[0]), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      wbm_ack[0] = 1'($urandom);
      tick();
      chk("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    end
    wbm_ack[0] = 1'b0;

    for (int k = 0; k < 40; k++) begin
      run_txn(k % 2, 1'($urandom), $urandom, $urandom, 4'($urandom),
              int'($urandom_range(0, 6)), $urandom, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
